// File: rtl/hhmm_pkg.sv
// Shared encodings for the stochastic HHMM level: parent mode codes, level phases
// and the wrap-around index helper used by the rotating-priority picker.
package hhmm_pkg;

  localparam logic [1:0] BV_SLEEP  = 2'd0;
  localparam logic [1:0] BV_SEARCH = 2'd1;
  localparam logic [1:0] BV_HOLD   = 2'd2;
  localparam logic [1:0] BV_INIT   = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } phase_e;

  // Index reached by stepping 'off' places from 'p' in a ring of 'n' entries.
  function automatic int rr_index(input int p, input int off, input int n);
    return (p + off) % n;
  endfunction

endpackage

// File: rtl/hhmm_rr_pick.sv
// Rotating-priority picker: first set bit of v at or after ptr, wrapping to
// the bottom of the vector. Outputs are don't-care (zero) when v is empty.
module hhmm_rr_pick
  import hhmm_pkg::*;
#(
  parameter int NS = 4,
  localparam int PW = (NS > 1) ? $clog2(NS) : 1
) (
  input  logic [NS-1:0] v,
  input  logic [PW-1:0] ptr,
  output logic [NS-1:0] onehot,
  output logic [PW-1:0] idx,
  output logic          any
);

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int i = 0; i < NS; i++) begin
      if (!any && v[rr_index(int'(ptr), i, NS)]) begin
        any = 1'b1;
        idx = PW'(rr_index(int'(ptr), i, NS));
        onehot[rr_index(int'(ptr), i, NS)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hhmm_level_n.sv
// N-state level of the stochastic hierarchical HMM: one-hot state driven by
// entry/transition/exit bitstreams, with suspend/resume and a transition counter.
module hhmm_level_n
  import hhmm_pkg::*;
#(
  parameter int NS = 4,
  parameter int CW = 8,
  localparam int PW = (NS > 1) ? $clog2(NS) : 1
) (
  input  logic             CLK,
  input  logic             INIT,
  input  logic [1:0]       BV,
  input  logic [NS-1:0]    P0,
  input  logic [NS*NS-1:0] A,
  input  logic [NS-1:0]    PE,
  output logic [NS-1:0]    S,
  output logic             T,
  output logic [NS-1:0]    S_MEM,
  output logic [CW-1:0]    NTRANS
);

  logic [NS-1:0] s_q, s_d;
  logic          t_q, t_d;
  logic [NS-1:0] s_mem_q, s_mem_d;
  logic [CW-1:0] ntrans_q, ntrans_d;
  logic [PW-1:0] ptr_q, ptr_d;
  phase_e        phase_q, phase_d;

  logic [PW-1:0] cur_k;
  logic [NS-1:0] row;
  logic [NS-1:0] pick_v, pick_onehot;
  logic [PW-1:0] pick_idx, ptr_after;
  logic          pick_any;

  always_comb begin
    cur_k = '0;
    for (int i = 0; i < NS; i++) begin
      if (s_q[i]) cur_k = PW'(i);
    end
  end

  assign row = A[int'(cur_k)*NS +: NS];

  // One picker serves both entry (IDLE) and horizontal moves (RUN).
  assign pick_v = (phase_q == IDLE) ? P0 : row;

  hhmm_rr_pick #(.NS(NS)) u_pick (
    .v      (pick_v),
    .ptr    (ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign ptr_after = (pick_idx == PW'(NS - 1)) ? '0 : pick_idx + PW'(1);

  always_comb begin
    s_d      = '0;
    t_d      = 1'b0;
    s_mem_d  = s_mem_q;
    ntrans_d = ntrans_q;
    ptr_d    = ptr_q;
    phase_d  = phase_q;
    unique case (BV)
      BV_SLEEP: phase_d = IDLE;
      BV_INIT: begin
        s_mem_d  = '0;
        ntrans_d = '0;
        ptr_d    = '0;
        phase_d  = IDLE;
      end
      BV_HOLD: begin
        if (phase_q == RUN) begin
          s_mem_d = s_q;
          phase_d = HOLD;
        end
      end
      BV_SEARCH: begin
        unique case (phase_q)
          IDLE: begin
            if (pick_any) begin
              s_d     = pick_onehot;
              ptr_d   = ptr_after;
              phase_d = RUN;
            end
          end
          RUN: begin
            // A pending transition beats a simultaneous exit request.
            if (pick_any) begin
              s_d   = pick_onehot;
              ptr_d = ptr_after;
              if (ntrans_q != '1) ntrans_d = ntrans_q + CW'(1);
            end else if (PE[cur_k]) begin
              t_d     = 1'b1;
              phase_d = DONE;
            end else begin
              s_d = s_q;
            end
          end
          HOLD: begin
            s_d     = s_mem_q;
            phase_d = RUN;
          end
          DONE: phase_d = DONE;
        endcase
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (INIT) begin
      s_q      <= '0;
      t_q      <= 1'b0;
      s_mem_q  <= '0;
      ntrans_q <= '0;
      ptr_q    <= '0;
      phase_q  <= IDLE;
    end else begin
      s_q      <= s_d;
      t_q      <= t_d;
      s_mem_q  <= s_mem_d;
      ntrans_q <= ntrans_d;
      ptr_q    <= ptr_d;
      phase_q  <= phase_d;
    end
  end

  assign S      = s_q;
  assign T      = t_q;
  assign S_MEM  = s_mem_q;
  assign NTRANS = ntrans_q;

endmodule

// File: tb/tb_hhmm_level_n.sv
// Directed vector bench for hhmm_level_n: a 4-state/8-bit instance driven from a
// table, plus a 2-bit-counter instance for saturation and exit-versus-move cases.
module tb_hhmm_level_n;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        init;
  logic [1:0]  bv;
  logic [3:0]  p0, pe;
  logic [15:0] a;
  logic [3:0]  s, s_mem;
  logic        t;
  logic [7:0]  ntrans;

  logic        init2;
  logic [1:0]  bv2;
  logic [3:0]  p0_2, pe_2;
  logic [15:0] a_2;
  logic [3:0]  s_2, s_mem_2;
  logic        t_2;
  logic [1:0]  ntrans_2;

  hhmm_level_n #(.NS(4), .CW(8)) dut (
    .CLK(clk), .INIT(init), .BV(bv), .P0(p0), .A(a), .PE(pe),
    .S(s), .T(t), .S_MEM(s_mem), .NTRANS(ntrans)
  );

  hhmm_level_n #(.NS(4), .CW(2)) dut_sat (
    .CLK(clk), .INIT(init2), .BV(bv2), .P0(p0_2), .A(a_2), .PE(pe_2),
    .S(s_2), .T(t_2), .S_MEM(s_mem_2), .NTRANS(ntrans_2)
  );

  typedef struct packed {
    logic        init;
    logic [1:0]  bv;
    logic [3:0]  p0;
    logic [15:0] a;
    logic [3:0]  pe;
    logic [3:0]  s;
    logic        t;
    logic [3:0]  smem;
    logic [7:0]  n;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [NV];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic vec_t mk(input logic i, input logic [1:0] b, input logic [3:0] p,
                              input logic [15:0] aa, input logic [3:0] e,
                              input logic [3:0] xs, input logic xt,
                              input logic [3:0] xm, input logic [7:0] xn);
    vec_t v;
    v = '{init: i, bv: b, p0: p, a: aa, pe: e, s: xs, t: xt, smem: xm, n: xn};
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic step_sat(input logic [1:0] b, input logic [15:0] aa, input logic [3:0] e);
    bv2 = b; a_2 = aa; pe_2 = e;
    @(posedge clk); #1;
  endtask

  initial begin
    init = 1'b1; bv = 2'd1; p0 = '0; a = '0; pe = '0;
    init2 = 1'b1; bv2 = 2'd1; p0_2 = '0; a_2 = '0; pe_2 = '0;

    vecs[0]  = mk(1, 1, 4'hF, 16'h0000, 4'h0, 4'h0, 0, 4'h0, 8'd0); // reset
    vecs[1]  = mk(0, 1, 4'hF, 16'h0000, 4'h0, 4'h1, 0, 4'h0, 8'd0); // entry, ptr->1
    vecs[2]  = mk(0, 1, 4'h0, 16'h0005, 4'h0, 4'h4, 0, 4'h0, 8'd1); // 0->2
    vecs[3]  = mk(0, 1, 4'h0, 16'h0500, 4'h0, 4'h1, 0, 4'h0, 8'd2); // 2->0 wrap
    vecs[4]  = mk(0, 1, 4'h0, 16'h0000, 4'h0, 4'h1, 0, 4'h0, 8'd2); // hold
    vecs[5]  = mk(0, 1, 4'h0, 16'h0004, 4'h0, 4'h4, 0, 4'h0, 8'd3); // 0->2
    vecs[6]  = mk(0, 1, 4'h0, 16'h0000, 4'h4, 4'h0, 1, 4'h0, 8'd3); // terminate
    vecs[7]  = mk(0, 1, 4'hF, 16'hFFFF, 4'h4, 4'h0, 0, 4'h0, 8'd3); // DONE
    vecs[8]  = mk(0, 1, 4'hF, 16'hFFFF, 4'h4, 4'h0, 0, 4'h0, 8'd3); // DONE
    vecs[9]  = mk(0, 3, 4'hF, 16'hFFFF, 4'hF, 4'h0, 0, 4'h0, 8'd0); // level init
    vecs[10] = mk(0, 1, 4'h8, 16'h0000, 4'h0, 4'h8, 0, 4'h0, 8'd0); // re-entry state 3
    vecs[11] = mk(0, 2, 4'hF, 16'hFFFF, 4'hF, 4'h0, 0, 4'h8, 8'd0); // suspend
    vecs[12] = mk(0, 2, 4'hF, 16'h1234, 4'h9, 4'h0, 0, 4'h8, 8'd0);
    vecs[13] = mk(0, 2, 4'h3, 16'hABCD, 4'h8, 4'h0, 0, 4'h8, 8'd0);
    vecs[14] = mk(0, 2, 4'h0, 16'hFFFF, 4'hF, 4'h0, 0, 4'h8, 8'd0);
    vecs[15] = mk(0, 2, 4'hF, 16'h0F0F, 4'h1, 4'h0, 0, 4'h8, 8'd0);
    vecs[16] = mk(0, 1, 4'h0, 16'hFFFF, 4'h0, 4'h8, 0, 4'h8, 8'd0); // resume, no move
    vecs[17] = mk(0, 1, 4'h0, 16'h2000, 4'h0, 4'h2, 0, 4'h8, 8'd1); // 3->1, ptr->2
    vecs[18] = mk(0, 0, 4'hF, 16'hFFFF, 4'hF, 4'h0, 0, 4'h8, 8'd1); // sleep keeps mem/count
    vecs[19] = mk(0, 1, 4'h0, 16'hFFFF, 4'hF, 4'h0, 0, 4'h8, 8'd1); // no entry request
    vecs[20] = mk(0, 1, 4'h3, 16'h0000, 4'h0, 4'h1, 0, 4'h8, 8'd1); // ptr=2 wraps to 0
    vecs[21] = mk(0, 1, 4'h0, 16'h0002, 4'h1, 4'h2, 0, 4'h8, 8'd2); // move beats exit
    vecs[22] = mk(1, 1, 4'h0, 16'h0000, 4'h0, 4'h0, 0, 4'h0, 8'd0); // INIT mid-run
    vecs[23] = mk(0, 1, 4'h0, 16'h0000, 4'h0, 4'h0, 0, 4'h0, 8'd0); // stays idle
    vecs[24] = mk(0, 2, 4'hF, 16'h0000, 4'h0, 4'h0, 0, 4'h0, 8'd0); // hold while idle
    vecs[25] = mk(0, 1, 4'hF, 16'h0000, 4'h0, 4'h1, 0, 4'h0, 8'd0); // still idle: entry

    for (int i = 0; i < NV; i++) begin
      init = vecs[i].init; bv = vecs[i].bv; p0 = vecs[i].p0;
      a = vecs[i].a; pe = vecs[i].pe;
      @(posedge clk); #1;
      chk("S", i, 32'(s), 32'(vecs[i].s));
      chk("T", i, 32'(t), 32'(vecs[i].t));
      chk("S_MEM", i, 32'(s_mem), 32'(vecs[i].smem));
      chk("NTRANS", i, 32'(ntrans), 32'(vecs[i].n));
      $display("[TB] vec %0d bv=%0d S=%b T=%b S_MEM=%b NTRANS=%0d", i, bv, s, t, s_mem, ntrans);
    end

    // Saturating counter with CW=2: self-loop on state 0 six times.
    init2 = 1'b0; p0_2 = 4'h1;
    step_sat(2'd1, 16'h0000, 4'h0);
    chk("sat_entry_S", 0, 32'(s_2), 32'h1);
    p0_2 = 4'h0;
    for (int i = 1; i <= 6; i++) begin
      step_sat(2'd1, 16'h0001, 4'h0);
      chk("sat_S", i, 32'(s_2), 32'h1);
      chk("sat_NTRANS", i, 32'(ntrans_2), (i < 3) ? 32'(i) : 32'd3);
      $display("[TB] sat cycle %0d S=%b NTRANS=%0d", i, s_2, ntrans_2);
    end
    step_sat(2'd1, 16'h0001, 4'h1);
    chk("sat_move_wins_T", 7, 32'(t_2), 32'h0);
    chk("sat_move_wins_S", 7, 32'(s_2), 32'h1);
    step_sat(2'd1, 16'h0000, 4'h1);
    chk("sat_exit_T", 8, 32'(t_2), 32'h1);
    chk("sat_exit_S", 8, 32'(s_2), 32'h0);
    step_sat(2'd1, 16'h0000, 4'h1);
    chk("sat_pulse_width_T", 9, 32'(t_2), 32'h0);
    chk("sat_NTRANS_kept", 9, 32'(ntrans_2), 32'd3);
    $display("[TB] sat tail T=%b S=%b NTRANS=%0d", t_2, s_2, ntrans_2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hhmm_level_n.md
Name: hhmm_level_n

Overview:
- Parametrised N-state level of the stochastic hierarchical HMM.
- Generalises the single-state level cell. It holds a one-hot active state driven by stochastic entry (P0), transition (A) and exit (PE) bitstreams, and raises a termination pulse to the parent level.
- New over the single-state cell:
  - horizontal transitions between NS states
  - rotating-priority tie-breaking
  - state retention across sub-level sleep
  - a saturating transition counter

Parameters:
- NS, 4, number of states in the level (2..16).
- CW, 8, width of the transition counter.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- INIT  input  1  synchronous, active-high reset of the whole block.
- BV  input  2  level mode from parent: 0 sleep, 1 search, 2 sub-level active (hold), 3 level init.
- P0  input  NS  entry stochastic bits; P0[i] requests entry into state i.
- A  input  NS*NS  transition stochastic bits; A[i*NS+j] requests the move i->j (j may equal i).
- PE  input  NS  exit stochastic bits; PE[i] requests termination from state i.
- S  output  NS  registered one-hot active state; all-zero when no state is visible.
- T  output  1  registered termination pulse, one cycle wide.
- S_MEM  output  NS  last state held while BV=2; restored on resume.
- NTRANS  output  CW  saturating count of transitions taken (entries excluded).

Behaviour:
- Reset:
  - INIT=1 at an edge forces S=0, T=0, S_MEM=0, NTRANS=0, ptr=0, phase=IDLE.
  - INIT has priority over BV.
- All outputs are registered. A decision made from inputs sampled at edge k appears at edge k.
- Internal phases: IDLE (no state), RUN (state k active), HOLD (suspended), DONE (terminated).
- BV=0 sleep:
  - S=0, T=0, phase=IDLE.
  - S_MEM and NTRANS are kept.
- BV=3 init:
  - S=0, T=0, S_MEM=0, NTRANS=0, ptr=0, phase=IDLE.
- BV=1 search, by phase:
  - IDLE: if any P0 bit is 1, enter state j = rr_pick(P0, ptr); S=onehot(j), phase=RUN, ptr=j+1 mod NS. NTRANS is unchanged. If P0=0, stay IDLE.
  - RUN, state k, with row R = A[k*NS +: NS]:
    - If PE[k]=1 and R=0: terminate. T=1, S=0, phase=DONE.
    - Else if R!=0: move to j = rr_pick(R, ptr). S=onehot(j), ptr=j+1 mod NS, NTRANS+1 saturating at 2^CW-1. A self-loop (j=k) counts as a transition.
    - Else: hold k.
    - When PE[k]=1 and R!=0, the transition wins.
  - HOLD: resume. S=S_MEM, phase=RUN. No decision is taken on the resume edge.
  - DONE: S=0, T=0. The phase stays DONE until BV=0 or BV=3, so the level never re-terminates or re-enters.
- BV=2 hold:
  - If phase=RUN: S_MEM=S, S=0, phase=HOLD.
  - If phase is IDLE or DONE: S=0, phase unchanged.
  - T is forced 0.
- rr_pick(v, p): the lowest index j ≥ p with v[j]=1, wrapping to 0..p-1. Defined only for v!=0.
- T is high for exactly one cycle per termination.
- S is never multi-hot.
- Changing BV mid-operation takes effect at the next edge per the rules above.

Decomposition:
- Package hhmm_pkg:
  - BV encodings BV_SLEEP=0, BV_SEARCH=1, BV_HOLD=2, BV_INIT=3.
  - Phase encodings IDLE, RUN, HOLD, DONE.
- Sub-module hhmm_rr_pick (parameter NS): combinational rotating-priority picker.
  - Inputs: v[NS], ptr[$clog2(NS)].
  - Outputs: onehot[NS], idx, any.
  - Instantiated once for the entry vector and once for the selected A row, or once with a muxed input.

Test Plan:
- INIT with BV=1, P0=4'b1111 -> S=0, T=0, NTRANS=0. After INIT drops: S=4'b0001 at the next edge, then ptr=1.
- RUN at state 0, ptr=1, A row 0 = 4'b0101, PE=0 -> S=4'b0100, NTRANS=1. Then row 2 = 4'b0101, ptr=3 -> S=4'b0001 (wrap), NTRANS=2.
- RUN at state 2, PE[2]=1, row 2 = 0 -> T=1 for one cycle, S=0. Held BV=1 with P0=4'b1111 -> S stays 0, T stays 0 (DONE). BV=3 then BV=1 -> re-entry occurs.
- RUN at state 3, BV=2 for 5 cycles with arbitrary A/PE -> S=0, S_MEM=4'b1000, NTRANS unchanged. BV=1 -> S=4'b1000 on the first edge; transitions resume on the second.
- CW=2, self-loop A[0]=1 held for 6 cycles -> NTRANS saturates at 3. PE[0]=1 with A[0]=1 -> no T (transition wins).
- INIT asserted mid-RUN with BV=1 and P0=0 -> S=0, S_MEM=0, NTRANS=0 on that edge; the block stays IDLE afterwards.
